// File: rtl/cla_pipe.sv
// cla_pipe: pipelined carry-lookahead adder/subtractor.
// The operands are split into GROUP-bit lookahead groups and each group gets its own
// register stage. The carry ripples one group per stage, so a result leaves every clock
// at any width. Operand slices that have not been used yet travel down the pipe beside
// the finished sum bits, so all WIDTH sum bits come out together.
module cla_pipe #(
  parameter int WIDTH = 8,
  parameter int GROUP = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int STAGES = WIDTH / GROUP;

  // The whole pipe moves together; it freezes only while a result waits at the output.
  logic w_adv;

  // Full lookahead across one group: each carry is a flat sum of products from the
  // group carry-in, with no ripple between bits. Returns {carry_out, sum}.
  function automatic logic [GROUP:0] claGroup(input logic [GROUP-1:0] x,
                                               input logic [GROUP-1:0] y,
                                               input logic             c0);
    logic [GROUP-1:0] p;
    logic [GROUP-1:0] g;
    logic [GROUP:0]   c;
    logic             t;
    p    = x ^ y;
    g    = x & y;
    c    = '0;
    c[0] = c0;
    for (int i = 0; i < GROUP; i++) begin
      t = c0;
      for (int j = 0; j <= i; j++) t = t & p[j];
      c[i+1] = t;
      for (int j = 0; j <= i; j++) begin
        t = g[j];
        for (int m = j + 1; m <= i; m++) t = t & p[m];
        c[i+1] = c[i+1] | t;
      end
    end
    return {c[GROUP], p ^ c[GROUP-1:0]};
  endfunction

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int LO = k * GROUP;
    localparam int HI = LO + GROUP;

    logic [WIDTH-LO-1:0] w_aIn;
    logic [WIDTH-LO-1:0] w_bIn;
    logic                w_sub;
    logic                w_c0;
    logic                w_vin;
    logic [GROUP-1:0]    w_bx;
    logic [GROUP:0]      w_res;
    logic [HI-1:0]       w_sumNext;

    logic [HI-1:0]       r_sum;
    logic                r_carry;
    logic                r_valid;

    if (k == 0) begin : g_first
      assign w_aIn     = a;
      assign w_bIn     = b;
      assign w_sub     = sub;
      assign w_c0      = sub ? 1'b1 : cin;
      assign w_vin     = in_valid;
      assign w_sumNext = w_res[GROUP-1:0];
    end else begin : g_next
      assign w_aIn     = g_stage[k-1].g_ops.r_a;
      assign w_bIn     = g_stage[k-1].g_ops.r_b;
      assign w_sub     = g_stage[k-1].g_ops.r_sub;
      assign w_c0      = g_stage[k-1].r_carry;
      assign w_vin     = g_stage[k-1].r_valid;
      assign w_sumNext = {w_res[GROUP-1:0], g_stage[k-1].r_sum};
    end

    assign w_bx  = w_bIn[GROUP-1:0] ^ {GROUP{w_sub}};
    assign w_res = claGroup(w_aIn[GROUP-1:0], w_bx, w_c0);

    // Stage register: sum bits resolved so far, this group's carry-out, and valid.
    always_ff @(posedge clk) begin
      if (rst) begin
        r_sum   <= '0;
        r_carry <= 1'b0;
        r_valid <= 1'b0;
      end else if (w_adv) begin
        r_sum   <= w_sumNext;
        r_carry <= w_res[GROUP];
        r_valid <= w_vin;
      end
    end

    if (k < STAGES - 1) begin : g_ops
      logic [WIDTH-HI-1:0] r_a;
      logic [WIDTH-HI-1:0] r_b;
      logic                r_sub;

      // Carry the still-unused upper operand slices and the op select to the next stage.
      always_ff @(posedge clk) begin
        if (rst) begin
          r_a   <= '0;
          r_b   <= '0;
          r_sub <= 1'b0;
        end else if (w_adv) begin
          r_a   <= w_aIn[WIDTH-LO-1:GROUP];
          r_b   <= w_bIn[WIDTH-LO-1:GROUP];
          r_sub <= w_sub;
        end
      end
    end

    if (k == STAGES - 1) begin : g_last
      logic r_ovf;

      // Signed overflow: carry into the MSB (sum ^ a ^ b at that bit) differs from carry out.
      always_ff @(posedge clk) begin
        if (rst) begin
          r_ovf <= 1'b0;
        end else if (w_adv) begin
          r_ovf <= w_res[GROUP-1] ^ w_aIn[GROUP-1] ^ w_bx[GROUP-1] ^ w_res[GROUP];
        end
      end
    end
  end

  assign out_valid = g_stage[STAGES-1].r_valid;
  assign s         = g_stage[STAGES-1].r_sum;
  assign cout      = g_stage[STAGES-1].r_carry;
  assign ovf       = g_stage[STAGES-1].g_last.r_ovf;
  assign w_adv     = !(out_valid && !out_ready);
  assign in_ready  = w_adv;

endmodule

// File: tb/tb_cla_pipe.sv
// tb_cla_pipe: directed vector table on an 8-bit/4-bit instance, hand-written stall and
// reset sequences, then a 32-bit instance with directed edges and a scoreboarded random run.
module tb_cla_pipe;

  logic clk = 1'b0;
  logic rst;

  logic [7:0]  a8, b8, s8;
  logic        cin8, sub8, inValid8, inReady8, cout8, ovf8, outValid8, outReady8;
  logic [31:0] a32, b32, s32;
  logic        cin32, sub32, inValid32, inReady32, cout32, ovf32, outValid32, outReady32;

  int nVec = 0;
  int nMis = 0;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       sub;
    logic [7:0] s;
    logic       cout;
    logic       ovf;
  } vec_t;

  vec_t vecs [12];
  logic [33:0] expQ [$];

  // Free-running clock shared by both instances.
  always #5 clk = ~clk;

  cla_pipe #(.WIDTH(8), .GROUP(4)) u_dut8 (
    .clk(clk), .rst(rst), .a(a8), .b(b8), .cin(cin8), .sub(sub8),
    .in_valid(inValid8), .in_ready(inReady8), .s(s8), .cout(cout8), .ovf(ovf8),
    .out_valid(outValid8), .out_ready(outReady8)
  );

  cla_pipe #(.WIDTH(32), .GROUP(4)) u_dut32 (
    .clk(clk), .rst(rst), .a(a32), .b(b32), .cin(cin32), .sub(sub32),
    .in_valid(inValid32), .in_ready(inReady32), .s(s32), .cout(cout32), .ovf(ovf32),
    .out_valid(outValid32), .out_ready(outReady32)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nVec++;
    if (act !== exp) begin
      nMis++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input vec_t v, input logic valid);
    a8       = v.a;
    b8       = v.b;
    cin8     = v.cin;
    sub8     = v.sub;
    inValid8 = valid;
  endtask

  task automatic checkVec(input string tag, input vec_t v);
    checkOutput({tag, " valid"}, {31'd0, outValid8}, 32'd1);
    checkOutput({tag, " s"},     {24'd0, s8},        {24'd0, v.s});
    checkOutput({tag, " cout"},  {31'd0, cout8},     {31'd0, v.cout});
    checkOutput({tag, " ovf"},   {31'd0, ovf8},      {31'd0, v.ovf});
  endtask

  // Independent arithmetic reference: {ovf, cout, sum}.
  function automatic logic [33:0] refModel(input logic [31:0] x, input logic [31:0] y,
                                           input logic c, input logic sb);
    logic [31:0] yx;
    logic [32:0] full;
    logic        ov;
    yx   = sb ? ~y : y;
    full = {1'b0, x} + {1'b0, yx} + {32'd0, (sb ? 1'b1 : c)};
    ov   = (x[31] == yx[31]) && (full[31] != x[31]);
    return {ov, full};
  endfunction

  // Compare the head of the scoreboard when the 32-bit DUT hands over a result.
  task automatic consume32();
    logic [33:0] e;
    if (outValid32 && outReady32) begin
      if (expQ.size() == 0) begin
        nVec++;
        nMis++;
        $display("[TB] FAIL sb unexpected: got s=0x%0h, expected no result", s32);
      end else begin
        e = expQ.pop_front();
        checkOutput("sb s",    s32,               e[31:0]);
        checkOutput("sb cout", {31'd0, cout32},   {31'd0, e[32]});
        checkOutput("sb ovf",  {31'd0, ovf32},    {31'd0, e[33]});
      end
    end
  endtask

  // Hard time limit so the bench always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main test sequence.
  initial begin
    vecs[0]  = '{8'd3,   8'd2,   1'b0, 1'b0, 8'd5,   1'b0, 1'b0};
    vecs[1]  = '{8'd0,   8'd1,   1'b1, 1'b0, 8'd2,   1'b0, 1'b0};
    vecs[2]  = '{8'd6,   8'd5,   1'b1, 1'b0, 8'd12,  1'b0, 1'b0};
    vecs[3]  = '{8'd7,   8'd7,   1'b1, 1'b0, 8'd15,  1'b0, 1'b0};
    vecs[4]  = '{8'd255, 8'd1,   1'b0, 1'b0, 8'd0,   1'b1, 1'b0};
    vecs[5]  = '{8'd127, 8'd1,   1'b0, 1'b0, 8'd128, 1'b0, 1'b1};
    vecs[6]  = '{8'd6,   8'd5,   1'b1, 1'b1, 8'd1,   1'b1, 1'b0};
    vecs[7]  = '{8'd2,   8'd7,   1'b0, 1'b1, 8'd251, 1'b0, 1'b0};
    vecs[8]  = '{8'd128, 8'd1,   1'b0, 1'b1, 8'd127, 1'b1, 1'b1};
    vecs[9]  = '{8'd200, 8'd100, 1'b0, 1'b0, 8'd44,  1'b1, 1'b0};
    vecs[10] = '{8'd0,   8'd0,   1'b1, 1'b1, 8'd0,   1'b1, 1'b0};
    vecs[11] = '{8'd128, 8'd128, 1'b0, 1'b0, 8'd0,   1'b1, 1'b1};

    rst = 1'b1;
    a8 = '0; b8 = '0; cin8 = 1'b0; sub8 = 1'b0; inValid8 = 1'b0; outReady8 = 1'b1;
    a32 = '0; b32 = '0; cin32 = 1'b0; sub32 = 1'b0; inValid32 = 1'b0; outReady32 = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
    checkOutput("rst valid",    {31'd0, outValid8},  32'd0);
    checkOutput("rst s",        {24'd0, s8},         32'd0);
    checkOutput("rst cout",     {31'd0, cout8},      32'd0);
    checkOutput("rst ovf",      {31'd0, ovf8},       32'd0);
    checkOutput("rst in_ready", {31'd0, inReady8},   32'd1);
    checkOutput("rst s32",      s32,                 32'd0);
    checkOutput("rst valid32",  {31'd0, outValid32}, 32'd0);

    // Single op: result appears one edge after acceptance and only for one cycle.
    applyStimulus(vecs[0], 1'b1);
    tick();
    checkOutput("single early", {31'd0, outValid8}, 32'd0);
    inValid8 = 1'b0;
    tick();
    checkVec("single", vecs[0]);
    tick();
    checkOutput("single pulse end", {31'd0, outValid8}, 32'd0);

    // Back-to-back table stream: one result per cycle, in order.
    for (int e = 0; e <= 12; e++) begin
      if (e < 12) applyStimulus(vecs[e], 1'b1);
      else inValid8 = 1'b0;
      tick();
      if (e >= 1) checkVec($sformatf("vec%0d", e - 1), vecs[e-1]);
    end
    tick();
    checkOutput("stream end", {31'd0, outValid8}, 32'd0);

    // Backpressure: hold the first result, pipe and input freeze, then release.
    applyStimulus(vecs[1], 1'b1);
    tick();
    applyStimulus(vecs[2], 1'b1);
    tick();
    checkVec("bp first", vecs[1]);
    outReady8 = 1'b0;
    applyStimulus(vecs[3], 1'b1);
    #1;
    checkOutput("bp in_ready low", {31'd0, inReady8}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkVec($sformatf("bp hold%0d", i), vecs[1]);
      checkOutput($sformatf("bp hold%0d in_ready", i), {31'd0, inReady8}, 32'd0);
    end
    outReady8 = 1'b1;
    #1;
    checkOutput("bp in_ready high", {31'd0, inReady8}, 32'd1);
    tick();
    checkVec("bp second", vecs[2]);
    applyStimulus(vecs[4], 1'b1);
    tick();
    checkVec("bp third", vecs[3]);
    inValid8 = 1'b0;
    tick();
    checkVec("bp fourth", vecs[4]);
    tick();
    checkOutput("bp drained", {31'd0, outValid8}, 32'd0);

    // Reset with two ops in flight: everything clears and nothing stale emerges.
    applyStimulus(vecs[5], 1'b1);
    tick();
    applyStimulus(vecs[4], 1'b1);
    tick();
    checkVec("pre-reset", vecs[5]);
    rst = 1'b1;
    inValid8 = 1'b0;
    tick();
    rst = 1'b0;
    checkOutput("mid rst valid", {31'd0, outValid8}, 32'd0);
    checkOutput("mid rst s",     {24'd0, s8},        32'd0);
    checkOutput("mid rst cout",  {31'd0, cout8},     32'd0);
    checkOutput("mid rst ovf",   {31'd0, ovf8},      32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput($sformatf("post rst valid%0d", i), {31'd0, outValid8}, 32'd0);
    end

    // 32-bit: eight-stage latency and full-width carry.
    a32 = 32'hFFFF_FFFF; b32 = 32'd0; cin32 = 1'b1; sub32 = 1'b0; inValid32 = 1'b1;
    tick();
    inValid32 = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      tick();
      checkOutput($sformatf("w32 early%0d", i), {31'd0, outValid32}, 32'd0);
    end
    tick();
    checkOutput("w32 carry valid", {31'd0, outValid32}, 32'd1);
    checkOutput("w32 carry s",     s32,                 32'd0);
    checkOutput("w32 carry cout",  {31'd0, cout32},     32'd1);
    checkOutput("w32 carry ovf",   {31'd0, ovf32},      32'd0);

    a32 = 32'h7FFF_FFFF; b32 = 32'd1; cin32 = 1'b0; sub32 = 1'b0; inValid32 = 1'b1;
    tick();
    inValid32 = 1'b0;
    for (int i = 0; i < 20 && !outValid32; i++) tick();
    checkOutput("w32 ovf valid", {31'd0, outValid32}, 32'd1);
    checkOutput("w32 ovf s",     s32,                 32'h8000_0000);
    checkOutput("w32 ovf cout",  {31'd0, cout32},     32'd0);
    checkOutput("w32 ovf ovf",   {31'd0, ovf32},      32'd1);
    for (int i = 0; i < 10; i++) tick();

    // 32-bit random traffic with random backpressure against the reference model.
    for (int i = 0; i < 400; i++) begin
      a32        = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
      b32        = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
      cin32      = 1'($urandom_range(0, 1));
      sub32      = 1'($urandom_range(0, 1));
      inValid32  = ($urandom_range(0, 3) != 0);
      outReady32 = ($urandom_range(0, 3) != 0);
      #1;
      consume32();
      if (inValid32 && inReady32) expQ.push_back(refModel(a32, b32, cin32, sub32));
      tick();
    end
    inValid32  = 1'b0;
    outReady32 = 1'b1;
    for (int i = 0; i < 40 && expQ.size() > 0; i++) begin
      #1;
      consume32();
      tick();
    end
    checkOutput("sb drain left", expQ.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

endmodule

// File: doc/cla_pipe.md
Name: cla_pipe

Overview:
- Parametrised, pipelined carry-lookahead adder/subtractor; successor to the fixed 8-bit combinational CLA.
- Operand width is split into GROUP-bit lookahead groups, with one register stage per group.
- Carry ripples group-to-group across stages, so throughput is one operation per clock at any width.
- Valid/ready handshake on input and output; sits in arithmetic datapaths that need wide adds at full clock rate.

Parameters:
WIDTH, 8, operand/sum width in bits; must be a multiple of GROUP, minimum GROUP.
GROUP, 4, lookahead group size in bits; also the number of sum bits resolved per pipeline stage.
(Derived) STAGES = WIDTH/GROUP; this is the pipeline latency in cycles.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
a  input  WIDTH  operand A (unsigned or two's complement)
b  input  WIDTH  operand B
cin  input  1  carry-in; used only when sub=0
sub  input  1  0: s = a + b + cin; 1: s = a - b (a + ~b + 1, cin ignored)
in_valid  input  1  a/b/cin/sub are valid this cycle
in_ready  output  1  block accepts an operation this cycle
s  output  WIDTH  result
cout  output  1  carry out of MSB (for sub: 1 = no borrow)
ovf  output  1  signed overflow
out_valid  output  1  s/cout/ovf hold a valid result
out_ready  input  1  downstream accepts the result

Behaviour:
- Reset (rst=1 at a clk edge): all stage valid bits, out_valid, s, cout and ovf become 0 at that edge; in-flight operations are discarded; in_ready=1 the cycle after reset deasserts.
- Global advance: adv = !(out_valid && !out_ready). in_ready = adv (combinational). All stages shift only when adv=1; otherwise every stage register holds.
- Transfer: input is accepted when in_valid && in_ready; output is consumed when out_valid && out_ready.
- Latency: an operation accepted at edge N appears on s/cout/ovf/out_valid after edge N+STAGES-1 when no stall occurs; each stall cycle adds one cycle.
- Stage k (0..STAGES-1):
  - Computes group-k generate/propagate from its registered a/b slice (b inverted if sub).
  - Applies 4-bit-style lookahead internally (no ripple inside a group), using the carry registered from stage k-1.
  - Stage 0 carry-in = sub ? 1 : cin.
  - Registers: sum slice k, group carry-out, remaining unconsumed operand slices, sub, and valid.
  - Skewed operand slices travel down the pipeline; completed sum slices are delayed so all WIDTH bits emerge aligned.
- ovf = carry into MSB XOR carry out of MSB, computed in the last stage.
- Bubbles: a stage whose valid=0 may hold any data, but out_valid=0 while it is at the output. s/cout/ovf are don't-care when out_valid=0, except after reset, when they are 0.
- Back-to-back operation: with in_valid=1 and out_ready=1 continuously, one result per cycle, in order; no gaps or reordering.
- Simultaneous accept and consume while full: allowed. adv=1 because out_ready=1.
- out_ready=0 with out_valid=0: no stall; bubbles are squeezed out.
- sub toggled between consecutive operations: each operation uses its own registered sub.
- Wrap-around: results are modulo 2^WIDTH; overflow is reported only via cout/ovf.
- Reset asserted mid-stall or mid-stream: reset wins over adv; the pipeline empties in one cycle.

Test Plan:
1. WIDTH=8, GROUP=4, out_ready=1. Issue a=3,b=2,cin=0,sub=0 alone -> out_valid pulses exactly 2 cycles later; s=5, cout=0, ovf=0.
2. Stream back-to-back (0,1,cin1), (6,5,cin1), (7,7,cin1), (255,1,cin0), (127,1,cin0) -> one result per cycle:
   - s=2, cout=0
   - s=12, cout=0
   - s=15, cout=0
   - s=0, cout=1, ovf=0
   - s=128, cout=0, ovf=1
3. Subtract, including cin=1 ignored: (6-5) -> s=1, cout=1, ovf=0; (2-7) -> s=251, cout=0; (128-1) -> s=127, ovf=1.
4. Backpressure: stream 4 ops and hold out_ready=0 once out_valid=1 -> in_ready=0, outputs stable for 3 cycles. Release -> the remaining results follow in order with none lost or duplicated.
5. Reset mid-stream: 2 ops in flight, rst=1 for one cycle -> next cycle out_valid=0, s=0, cout=0, ovf=0; no stale result ever emerges.
6. WIDTH=32, GROUP=4 -> latency 8. 0xFFFFFFFF+0+cin1 -> s=0, cout=1. 0x7FFFFFFF+1 -> s=0x80000000, ovf=1. Randomised ops with random out_ready are checked against a reference model.
